control_unit: RTL and testbench
===============================

Name: control_unit

Overview:
- Multi-cycle FSM that sequences the CPU datapath: PC, instruction ROM, IR, register file, reg A/B, ALU, ACC, flags, MAR/MDR, data RAM.
- Decodes the IR opcode and flags, then drives every register write-enable, mux select and ALU operation.
- Handshakes with data RAM through a req/ready pair.
- Pure controller: holds no datapath values.

Parameters:
- OPCODE_W, 4, width of the opcode field taken from IR.
- ALU_OP_W, 3, width of the ALU operation select.
- MEM_TIMEOUT, 15, max cycles to wait for mem_ready before flagging a bus error. Must be ≥1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  OPCODE_W  IR opcode field
- flag_z  in  1  zero flag from flags register
- mem_ready  in  1  RAM completed the access this cycle
- pc_we  out  1  PC load
- pc_src  out  1  0 = adder (PC+1), 1 = branch/jump target
- ir_we  out  1  IR load from ROM
- rega_we, regb_we  out  1 each  latch RF read ports
- alu_src_b  out  1  0 = reg B, 1 = sign-extended immediate
- alu_op  out  ALU_OP_W  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 PASS_B
- acc_we  out  1  ACC load from ALU
- flags_we  out  1  flags load from ALU
- mar_we  out  1  MAR load from ACC
- mdr_we  out  1  MDR load (RAM read data)
- mem_req  out  1  RAM access request
- mem_we  out  1  RAM write (valid with mem_req)
- rf_we  out  1  register file write
- rf_wsel  out  1  0 = ACC, 1 = MDR
- halted  out  1  FSM in HALT
- fault  out  2  0 none, 1 illegal opcode, 2 memory timeout (sticky)

Behaviour:
- Reset (async, rst_n=0):
  - state=FETCH.
  - All outputs 0; fault=0; timeout counter=0.
- All control outputs are Moore: decoded from registered state plus registered opcode/flag_z sampled in DECODE. No combinational path from mem_ready to any enable except the cycle mdr_we/state advance.
- States and transitions:
  - FETCH: ir_we=1, pc_we=1, pc_src=0 → DECODE.
  - DECODE: rega_we=regb_we=1; latch opcode.
    - ADD/SUB/AND/OR/XOR (op 1-5), ADDI (6) → EXEC.
    - LD (7), ST (8) → MEM_ADDR.
    - BEQ (9), BNE (A), JMP (B) → BRANCH.
    - NOP (0) → FETCH.
    - HALT (F) → HALT.
    - Others (C-E) → HALT with fault=1.
  - EXEC:
    - acc_we=1, flags_we=1.
    - alu_op = opcode-1 for ops 1-5; ADDI uses ADD with alu_src_b=1.
    - → WB.
  - WB: rf_we=1, rf_wsel=0 → FETCH.
  - MEM_ADDR: alu_op=ADD, alu_src_b=1, acc_we=1 (flags untouched) → MEM_AR.
  - MEM_AR: mar_we=1 → MEM_RD (LD) or MEM_WR (ST).
  - MEM_RD:
    - mem_req=1, mem_we=0.
    - On mem_ready: mdr_we=1 → LD_WB.
    - Otherwise stay.
  - LD_WB: rf_we=1, rf_wsel=1 → FETCH.
  - MEM_WR:
    - mem_req=1, mem_we=1.
    - On mem_ready → FETCH; otherwise stay.
    - mem_req and mem_we are held stable until mem_ready.
  - BRANCH:
    - Taken = JMP, or BEQ with flag_z=1, or BNE with flag_z=0.
    - If taken: pc_we=1, pc_src=1.
    - → FETCH.
  - HALT: halted=1; all enables 0; remain until reset.
- Timeout:
  - Counter increments each cycle in MEM_RD/MEM_WR without mem_ready; clears on state exit.
  - Reaching MEM_TIMEOUT → HALT, fault=2, mem_req drops the next cycle.
- mem_ready outside MEM_RD/MEM_WR is ignored.
- Latencies, in cycles, with zero-wait RAM:
  - R-type: 4
  - NOP: 2
  - Branch: 3
  - LD: 6
  - ST: 5
- Reset mid-access drops mem_req asynchronously.
- fault holds its first non-zero value until reset.

Optional Feature:
CTRL_SINGLE_STEP_EN
- Adds input step (1 bit).
- With macro defined: the FSM waits in FETCH with all enables 0 until step is sampled 1, then executes exactly one instruction. step must be pulsed again for the next instruction; holding step high runs continuously.
- Without macro: port absent, FETCH proceeds unconditionally.

Test Plan:
- Reset: assert rst_n=0 mid-MEM_RD → next edge state=FETCH, mem_req=0, fault=0, all enables 0.
- ADD (op 1): FETCH ir_we/pc_we, DECODE rega/regb_we, EXEC acc_we+flags_we with alu_op=0, WB rf_we with rf_wsel=0 → exactly 4 cycles.
- LD with mem_ready delayed 3 cycles: mem_req=1/mem_we=0 held 4 cycles, mdr_we=1 only on the ready cycle, then rf_we with rf_wsel=1. ST with immediate ready: mem_we=1 for 1 cycle.
- BEQ with flag_z=1 → pc_we=1, pc_src=1 in BRANCH. BEQ with flag_z=0 → pc_we=0. BNE mirrored. JMP always taken.
- Opcode 0xC → halted=1, fault=1 and held. LD with mem_ready never asserted → after 15 wait cycles halted=1, fault=2, mem_req=0.
- With CTRL_SINGLE_STEP_EN: step=0 for 10 cycles → no ir_we. One step pulse → one ADD completes, then FETCH waits again.

Source files
------------

// File: rtl/control_unit_if.sv
// Data RAM request/ready handshake between the control unit and memory.
interface control_unit_if;
  logic mem_req;
  logic mem_we;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    output mem_ready
  );
endinterface

// File: rtl/control_unit.sv
// Multi-cycle FSM sequencer for the CPU datapath (Moore control outputs).
// Optional CTRL_SINGLE_STEP_EN adds a step input gating each fetch.
module control_unit #(
  parameter int OPCODE_W    = 4,
  parameter int ALU_OP_W    = 3,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic                step,
`endif
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                flag_z,
  control_unit_if.master      mem,
  output logic                pc_we,
  output logic                pc_src,
  output logic                ir_we,
  output logic                rega_we,
  output logic                regb_we,
  output logic                alu_src_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                acc_we,
  output logic                flags_we,
  output logic                mar_we,
  output logic                mdr_we,
  output logic                rf_we,
  output logic                rf_wsel,
  output logic                halted,
  output logic [1:0]          fault
);

  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC, WB,
    MEM_ADDR, MEM_AR, MEM_RD, LD_WB,
    MEM_WR, BRANCH, HALT
  } state_t;

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(MEM_TIMEOUT - 1);

  localparam logic [OPCODE_W-1:0] OP_NOP  = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_ADD  = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OP_LD   = OPCODE_W'(7);
  localparam logic [OPCODE_W-1:0] OP_ST   = OPCODE_W'(8);
  localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(9);
  localparam logic [OPCODE_W-1:0] OP_BNE  = OPCODE_W'(10);
  localparam logic [OPCODE_W-1:0] OP_JMP  = OPCODE_W'(11);
  localparam logic [OPCODE_W-1:0] OP_HALT = OPCODE_W'(15);

  localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(0);

  state_t              st, nxt;
  logic [OPCODE_W-1:0] op_q;
  logic                flag_q;
  logic [CW-1:0]       cnt;
  logic [1:0]          fault_q, fault_nxt;
  logic                go;
  logic                taken;
  logic                d_nop, d_alu, d_mem, d_br, d_hlt;

`ifdef CTRL_SINGLE_STEP_EN
  logic step_pend;

  // A pulse seen mid-instruction is kept so the next fetch still runs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_pend <= 1'b0;
    end else begin
      step_pend <= (st == FETCH) ? 1'b0 : (step_pend | step);
    end
  end

  assign go = step | step_pend;
`else
  assign go = 1'b1;
`endif

  assign d_nop = (opcode == OP_NOP);
  assign d_alu = (opcode >= OP_ADD) && (opcode <= OP_ADDI);
  assign d_mem = (opcode == OP_LD) || (opcode == OP_ST);
  assign d_br  = (opcode >= OP_BEQ) && (opcode <= OP_JMP);
  assign d_hlt = (opcode == OP_HALT);

  assign taken = (op_q == OP_JMP)
               | ((op_q == OP_BEQ) & flag_q)
               | ((op_q == OP_BNE) & ~flag_q);

  assign fault = fault_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= FETCH;
      op_q    <= '0;
      flag_q  <= 1'b0;
      cnt     <= '0;
      fault_q <= 2'd0;
    end else begin
      st      <= nxt;
      fault_q <= fault_nxt;
      if (st == DECODE) begin
        op_q   <= opcode;
        flag_q <= flag_z;
      end
      if ((nxt == st) && ((st == MEM_RD) || (st == MEM_WR))) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
    end
  end

  // Enables are forced low while rst_n is held so reset is quiet.
  always_comb begin
    nxt          = st;
    fault_nxt    = fault_q;
    pc_we        = 1'b0;
    pc_src       = 1'b0;
    ir_we        = 1'b0;
    rega_we      = 1'b0;
    regb_we      = 1'b0;
    alu_src_b    = 1'b0;
    alu_op       = ALU_ADD;
    acc_we       = 1'b0;
    flags_we     = 1'b0;
    mar_we       = 1'b0;
    mdr_we       = 1'b0;
    mem.mem_req  = 1'b0;
    mem.mem_we   = 1'b0;
    rf_we        = 1'b0;
    rf_wsel      = 1'b0;
    halted       = 1'b0;
    if (rst_n) begin
      unique case (st)
        FETCH: begin
          if (go) begin
            ir_we = 1'b1;
            pc_we = 1'b1;
            nxt   = DECODE;
          end
        end
        DECODE: begin
          rega_we = 1'b1;
          regb_we = 1'b1;
          unique case (1'b1)
            d_nop:   nxt = FETCH;
            d_alu:   nxt = EXEC;
            d_mem:   nxt = MEM_ADDR;
            d_br:    nxt = BRANCH;
            d_hlt:   nxt = HALT;
            default: begin
              nxt       = HALT;
              fault_nxt = 2'd1;
            end
          endcase
        end
        EXEC: begin
          acc_we   = 1'b1;
          flags_we = 1'b1;
          if (op_q == OP_ADDI) begin
            alu_src_b = 1'b1;
          end else begin
            alu_op = ALU_OP_W'(op_q - OP_ADD);
          end
          nxt = WB;
        end
        WB: begin
          rf_we = 1'b1;
          nxt   = FETCH;
        end
        MEM_ADDR: begin
          alu_src_b = 1'b1;
          acc_we    = 1'b1;
          nxt       = MEM_AR;
        end
        MEM_AR: begin
          mar_we = 1'b1;
          nxt    = (op_q == OP_LD) ? MEM_RD : MEM_WR;
        end
        MEM_RD: begin
          mem.mem_req = 1'b1;
          if (mem.mem_ready) begin
            mdr_we = 1'b1;
            nxt    = LD_WB;
          end else if (cnt == TO_LAST) begin
            nxt       = HALT;
            fault_nxt = 2'd2;
          end
        end
        LD_WB: begin
          rf_we   = 1'b1;
          rf_wsel = 1'b1;
          nxt     = FETCH;
        end
        MEM_WR: begin
          mem.mem_req = 1'b1;
          mem.mem_we  = 1'b1;
          if (mem.mem_ready) begin
            nxt = FETCH;
          end else if (cnt == TO_LAST) begin
            nxt       = HALT;
            fault_nxt = 2'd2;
          end
        end
        BRANCH: begin
          pc_we  = taken;
          pc_src = taken;
          nxt    = FETCH;
        end
        HALT: begin
          halted = 1'b1;
        end
        default: nxt = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Table-driven bench for control_unit: per-cycle control words.
module tb_control_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [3:0] opcode;
  logic       flag_z;
  logic       pc_we, pc_src, ir_we, rega_we, regb_we, alu_src_b;
  logic [2:0] alu_op;
  logic       acc_we, flags_we, mar_we, mdr_we, rf_we, rf_wsel, halted;
  logic [1:0] fault;
`ifdef CTRL_SINGLE_STEP_EN
  logic       step;
`endif

  control_unit_if mif();

  control_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef CTRL_SINGLE_STEP_EN
    .step      (step),
`endif
    .opcode    (opcode),
    .flag_z    (flag_z),
    .mem       (mif.master),
    .pc_we     (pc_we),
    .pc_src    (pc_src),
    .ir_we     (ir_we),
    .rega_we   (rega_we),
    .regb_we   (regb_we),
    .alu_src_b (alu_src_b),
    .alu_op    (alu_op),
    .acc_we    (acc_we),
    .flags_we  (flags_we),
    .mar_we    (mar_we),
    .mdr_we    (mdr_we),
    .rf_we     (rf_we),
    .rf_wsel   (rf_wsel),
    .halted    (halted),
    .fault     (fault)
  );

  wire [17:0] word = {pc_we, pc_src, ir_we, rega_we, regb_we,
                      alu_src_b, alu_op, acc_we, flags_we, mar_we,
                      mdr_we, mif.mem_req, mif.mem_we, rf_we,
                      rf_wsel, halted};

  // pcw pcs irw | ra rb sb | aluop | acc flg mar mdr | req we | rfw wsel hlt
  localparam logic [17:0] C_0   = 18'b000_000_000_0000_00_000;
  localparam logic [17:0] C_F   = 18'b101_000_000_0000_00_000;
  localparam logic [17:0] C_D   = 18'b000_110_000_0000_00_000;
  localparam logic [17:0] C_EAD = 18'b000_000_000_1100_00_000;
  localparam logic [17:0] C_ESU = 18'b000_000_001_1100_00_000;
  localparam logic [17:0] C_EAN = 18'b000_000_010_1100_00_000;
  localparam logic [17:0] C_EOR = 18'b000_000_011_1100_00_000;
  localparam logic [17:0] C_EXO = 18'b000_000_100_1100_00_000;
  localparam logic [17:0] C_EAI = 18'b000_001_000_1100_00_000;
  localparam logic [17:0] C_WB  = 18'b000_000_000_0000_00_100;
  localparam logic [17:0] C_MA  = 18'b000_001_000_1000_00_000;
  localparam logic [17:0] C_AR  = 18'b000_000_000_0010_00_000;
  localparam logic [17:0] C_RDW = 18'b000_000_000_0000_10_000;
  localparam logic [17:0] C_RDR = 18'b000_000_000_0001_10_000;
  localparam logic [17:0] C_LWB = 18'b000_000_000_0000_00_110;
  localparam logic [17:0] C_WR  = 18'b000_000_000_0000_11_000;
  localparam logic [17:0] C_BT  = 18'b110_000_000_0000_00_000;
  localparam logic [17:0] C_H   = 18'b000_000_000_0000_00_001;

  typedef struct {
    logic [3:0]  op;
    logic        fz;
    logic        rdy;
    logic [17:0] exp;
    logic [1:0]  flt;
  } vec_t;

  vec_t tv[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string nm, input logic [19:0] got,
                     input logic [19:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b want %b", nm, got, exp);
  endtask

  task automatic add(input logic [3:0] op, input logic fz,
                     input logic rdy, input logic [17:0] exp,
                     input logic [1:0] flt);
    vec_t v;
    v.op  = op;
    v.fz  = fz;
    v.rdy = rdy;
    v.exp = exp;
    v.flt = flt;
    tv.push_back(v);
  endtask

  // Called #1 after a rising edge; leaves the same phase.
  task automatic run_tv(input string tag);
    for (int i = 0; i < tv.size(); i++) begin
      opcode        = tv[i].op;
      flag_z        = tv[i].fz;
      mif.mem_ready = tv[i].rdy;
      @(negedge clk);
      chk($sformatf("%s[%0d]", tag, i), {word, fault},
          {tv[i].exp, tv[i].flt});
      @(posedge clk);
      #1;
    end
    tv.delete();
  endtask

  task automatic do_reset(input string tag);
    rst_n         = 1'b0;
    mif.mem_ready = 1'b0;
    @(negedge clk);
    chk(tag, {word, fault}, 20'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n         = 1'b0;
    opcode        = 4'h0;
    flag_z        = 1'b0;
    mif.mem_ready = 1'b0;
`ifdef CTRL_SINGLE_STEP_EN
    step          = 1'b1;
`endif
    repeat (2) @(posedge clk);
    #1;
    do_reset("reset_init");

    // ADD, SUB (opcode changed after DECODE), AND, OR, XOR, ADDI
    add(4'h1, 0, 0, C_F, 0);   add(4'h1, 0, 0, C_D, 0);
    add(4'h1, 0, 0, C_EAD, 0); add(4'h1, 0, 0, C_WB, 0);
    add(4'h2, 0, 0, C_F, 0);   add(4'h2, 0, 0, C_D, 0);
    add(4'h0, 0, 0, C_ESU, 0); add(4'h0, 0, 0, C_WB, 0);
    add(4'h3, 0, 0, C_F, 0);   add(4'h3, 0, 0, C_D, 0);
    add(4'h3, 0, 0, C_EAN, 0); add(4'h3, 0, 0, C_WB, 0);
    add(4'h4, 0, 0, C_F, 0);   add(4'h4, 0, 0, C_D, 0);
    add(4'h4, 0, 0, C_EOR, 0); add(4'h4, 0, 0, C_WB, 0);
    add(4'h5, 0, 0, C_F, 0);   add(4'h5, 0, 0, C_D, 0);
    add(4'h5, 0, 0, C_EXO, 0); add(4'h5, 0, 0, C_WB, 0);
    add(4'h6, 0, 0, C_F, 0);   add(4'h6, 0, 0, C_D, 0);
    add(4'h6, 0, 0, C_EAI, 0); add(4'h6, 0, 0, C_WB, 0);
    // NOP, with stray mem_ready
    add(4'h0, 0, 1, C_F, 0);   add(4'h0, 0, 1, C_D, 0);
    // BEQ z=1 (flag flips after DECODE), BEQ z=0, BNE z=0/1, JMP
    add(4'h9, 1, 0, C_F, 0);   add(4'h9, 1, 0, C_D, 0);
    add(4'h9, 0, 0, C_BT, 0);
    add(4'h9, 0, 0, C_F, 0);   add(4'h9, 0, 0, C_D, 0);
    add(4'h9, 1, 0, C_0, 0);
    add(4'hA, 0, 0, C_F, 0);   add(4'hA, 0, 0, C_D, 0);
    add(4'hA, 0, 0, C_BT, 0);
    add(4'hA, 1, 0, C_F, 0);   add(4'hA, 1, 0, C_D, 0);
    add(4'hA, 1, 0, C_0, 0);
    add(4'hB, 1, 0, C_F, 0);   add(4'hB, 1, 0, C_D, 0);
    add(4'hB, 1, 0, C_BT, 0);
    // LD, ready after 3 wait cycles; ready in MEM_ADDR is ignored
    add(4'h7, 0, 0, C_F, 0);   add(4'h7, 0, 0, C_D, 0);
    add(4'h7, 0, 1, C_MA, 0);  add(4'h7, 0, 0, C_AR, 0);
    add(4'h7, 0, 0, C_RDW, 0); add(4'h7, 0, 0, C_RDW, 0);
    add(4'h7, 0, 0, C_RDW, 0); add(4'h7, 0, 1, C_RDR, 0);
    add(4'h7, 0, 0, C_LWB, 0);
    // ST, immediate ready
    add(4'h8, 0, 0, C_F, 0);   add(4'h8, 0, 0, C_D, 0);
    add(4'h8, 0, 0, C_MA, 0);  add(4'h8, 0, 0, C_AR, 0);
    add(4'h8, 0, 1, C_WR, 0);
    add(4'h1, 0, 0, C_F, 0);
    run_tv("main");

    // Illegal opcode: sticky halt with fault 1
    do_reset("reset_a");
    add(4'hC, 0, 0, C_F, 0);   add(4'hC, 0, 0, C_D, 0);
    add(4'h1, 0, 1, C_H, 1);   add(4'h7, 0, 1, C_H, 1);
    add(4'h0, 0, 0, C_H, 1);
    run_tv("illegal");

    // HALT opcode: halted, no fault
    do_reset("reset_b");
    add(4'hF, 0, 0, C_F, 0);   add(4'hF, 0, 0, C_D, 0);
    add(4'h1, 0, 0, C_H, 0);   add(4'h1, 0, 0, C_H, 0);
    run_tv("halt");

    // LD that never gets ready: 15 wait cycles then HALT fault 2
    do_reset("reset_c");
    add(4'h7, 0, 0, C_F, 0);   add(4'h7, 0, 0, C_D, 0);
    add(4'h7, 0, 0, C_MA, 0);  add(4'h7, 0, 0, C_AR, 0);
    for (int i = 0; i < 15; i++) add(4'h7, 0, 0, C_RDW, 0);
    add(4'h7, 0, 0, C_H, 2);   add(4'h7, 0, 1, C_H, 2);
    run_tv("timeout");

    // Reset asserted mid MEM_RD drops mem_req without a clock edge
    do_reset("reset_d");
    add(4'h7, 0, 0, C_F, 0);   add(4'h7, 0, 0, C_D, 0);
    add(4'h7, 0, 0, C_MA, 0);  add(4'h7, 0, 0, C_AR, 0);
    add(4'h7, 0, 0, C_RDW, 0); add(4'h7, 0, 0, C_RDW, 0);
    run_tv("ld_pre");
    rst_n = 1'b0;
    #1;
    chk("rst_async", {word, fault}, 20'd0);
    @(negedge clk);
    chk("rst_hold", {word, fault}, 20'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    add(4'h1, 0, 0, C_F, 0);   add(4'h1, 0, 0, C_D, 0);
    add(4'h1, 0, 0, C_EAD, 0); add(4'h1, 0, 0, C_WB, 0);
    run_tv("recover");

`ifdef CTRL_SINGLE_STEP_EN
    step = 1'b0;
    do_reset("reset_e");
    add(4'h1, 0, 0, C_0, 0);
    for (int i = 0; i < 9; i++) add(4'h1, 0, 0, C_0, 0);
    run_tv("step_idle");
    step = 1'b1;
    opcode = 4'h1;
    @(negedge clk);
    chk("step_fetch", {word, fault}, {C_F, 2'd0});
    @(posedge clk);
    #1;
    step = 1'b0;
    add(4'h1, 0, 0, C_D, 0);   add(4'h1, 0, 0, C_EAD, 0);
    add(4'h1, 0, 0, C_WB, 0);  add(4'h1, 0, 0, C_0, 0);
    add(4'h1, 0, 0, C_0, 0);   add(4'h1, 0, 0, C_0, 0);
    run_tv("step_one");
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
